// File: rtl/ps2_host_tx_if.sv
// Host-side command interface of the PS/2 host transmitter.
// The master issues command bytes and observes completion. The slave is the
// transmitter, which reports ready/busy, a done or error pulse, and the
// error code of the last failed transmission.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device using the inhibit / request-to-send
// sequence. The open-drain clock and data pins are driven through active-high
// "pull low" enables. The device acknowledge is checked after the stop bit.
// ps2_clk is synchronized and then glitch-filtered. ps2_dat is only
// synchronized, because it is sampled on filtered clock edges.
// Optional feature macro: PS2_HOST_TX_RETRY_EN. When it is defined, a failed
// transmission is retried up to two times before the error is reported.
// INHIBIT_CYCLES must be at least 2.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int FRAME_TIMEOUT  = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam int TW  = 21;
  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_FRAME = 2'b10;
  localparam logic [1:0] ERR_NOACK = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Saturating increment so that a stalled timer never wraps back below a limit.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Input conditioning state.
  logic           clk_s1_q, clk_s2_q;
  logic           dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall_q, fall_d;

  // Transmit control state.
  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [8:0]     shreg_q, shreg_d;
  logic           clk_oe_q, clk_oe_d;
  logic           dat_oe_q, dat_oe_d;
  logic           tx_done_q, tx_done_d;
  logic           tx_err_q, tx_err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           err_hit;
  logic [1:0]     err_val;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [7:0]     byte_q, byte_d;
  logic [1:0]     retry_q, retry_d;
`endif

  // Two-flop synchronizers for both pins; the lines idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat_in;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Stability filter: a new clock level is accepted after FILTER_LEN consecutive differing cycles.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Filter state register; the filtered level is preset to the idle-high value.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
    end
  end

  // Transmit sequencer: next state, line drive, timers and result reporting.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    err_code_d = err_code_q;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    err_hit    = 1'b0;
    err_val    = ERR_NONE;
`ifdef PS2_HOST_TX_RETRY_EN
    byte_d     = byte_q;
    retry_d    = retry_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (bus.tx_valid) begin
          shreg_d    = {~^bus.tx_data, bus.tx_data};
          err_code_d = ERR_NONE;
          timer_d    = '0;
          clk_oe_d   = 1'b1;
          state_d    = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          byte_d     = bus.tx_data;
          retry_d    = 2'd0;
`endif
        end
      end

      S_INHIBIT: begin
        // Falls here are caused by our own clock pull and are ignored.
        // The timer only runs while the clock is actually held low, so a retry
        // that enters with the clock released gets a full inhibit period.
        if (!clk_oe_q) begin
          clk_oe_d = 1'b1;
        end else begin
          timer_d = sat_inc(timer_q);
          if (timer_q == TW'(INHIBIT_CYCLES - 2)) begin
            dat_oe_d = 1'b1;
          end
          if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
            clk_oe_d  = 1'b0;
            timer_d   = '0;
            bit_cnt_d = 4'd0;
            state_d   = S_SEND;
          end
        end
      end

      S_SEND: begin
        timer_d = sat_inc(timer_q);
        if (fall_q) begin
          // A fall always wins over a timeout in the same cycle.
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            timer_d = '0;
          end
          if (bit_cnt_q < 4'd9) begin
            dat_oe_d = ~shreg_q[0];
            shreg_d  = {1'b0, shreg_q[8:1]};
          end else begin
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end
        end else if (bit_cnt_q == 4'd0) begin
          if (timer_q >= TW'(START_TIMEOUT)) begin
            err_hit = 1'b1;
            err_val = ERR_START;
          end
        end else if (timer_q >= TW'(FRAME_TIMEOUT)) begin
          err_hit = 1'b1;
          err_val = ERR_FRAME;
        end
      end

      S_ACK: begin
        timer_d = sat_inc(timer_q);
        if (fall_q) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!dat_s2_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            err_hit = 1'b1;
            err_val = ERR_NOACK;
          end
        end else if (timer_q >= TW'(FRAME_TIMEOUT)) begin
          err_hit = 1'b1;
          err_val = ERR_FRAME;
        end
      end

      S_WAIT_IDLE: begin
        timer_d = sat_inc(timer_q);
        if (filt_q && dat_s2_q) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end else if (timer_q >= TW'(FRAME_TIMEOUT)) begin
          err_hit = 1'b1;
          err_val = ERR_FRAME;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // Any failure releases both lines first.
    if (err_hit) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      if (retry_q < 2'd2) begin
        retry_d = retry_q + 2'd1;
        timer_d = '0;
        shreg_d = {~^byte_q, byte_q};
        state_d = S_INHIBIT;
      end else begin
        err_code_d = err_val;
        tx_err_d   = 1'b1;
        state_d    = S_IDLE;
      end
`else
      err_code_d = err_val;
      tx_err_d   = 1'b1;
      state_d    = S_IDLE;
`endif
    end
  end

  // Control registers; reset releases both lines on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      err_code_q <= err_code_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  // Data registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef PS2_HOST_TX_RETRY_EN
    byte_q  <= byte_d;
`endif
  end

  assign ps2_clk_oe   = clk_oe_q;
  assign ps2_dat_oe   = dat_oe_q;
  assign bus.tx_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_err   = tx_err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx.
// Directed commands are sent against a behavioural PS/2 device model.
// Expected results go into a scoreboard queue, and a monitor compares them
// when tx_done or tx_err pulses. Timeouts are scaled down to keep the run short.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 120;
  localparam int STO  = 3000;
  localparam int FTO  = 2000;
  localparam int FILT = 8;
  localparam int HP   = 40;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic        chk_bits;
    logic [10:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic glitch = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int run_len = 0;
  int inh_len = 0;
  int inh_runs = 0;
  int ready_hi = 0;
  int fall1_cyc = 0;
  int dev_falls = 0;
  int last_out_cyc = 0;
  logic [10:0] dev_bits = '1;
  exp_t sb[$];
  int done_log[$];

  ps2_host_tx_if bus();

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low) ^ glitch;
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .FRAME_TIMEOUT (FTO),
    .FILTER_LEN    (FILT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic is_err, input logic [1:0] code, input logic chk, input logic [10:0] bits);
    exp_t e;
    e.is_err = is_err;
    e.code = code;
    e.chk_bits = chk;
    e.bits = bits;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: compares each completion pulse with the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && (bus.tx_done || bus.tx_err)) begin
      last_out_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_output", 32'({bus.tx_done, bus.tx_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_is_err", 32'(bus.tx_err), 32'(e.is_err));
        check("err_code", 32'(bus.err_code), 32'(e.code));
        if (e.chk_bits) check("frame_bits", 32'(dev_bits), 32'(e.bits));
        if (bus.tx_done) done_log.push_back(cyc);
      end
    end
  end

  // Measures the length of each clock-inhibit pulse.
  initial forever begin
    @(negedge clk);
    if (ps2_clk_oe) run_len++;
    else if (run_len != 0) begin
      inh_len = run_len;
      inh_runs++;
      run_len = 0;
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus.tx_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.tx_ready) check("accept_wait", 32'(bus.tx_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic half(input bit g);
    repeat (15) @(negedge clk);
    if (g) glitch = 1'b1;
    repeat (3) @(negedge clk);
    glitch = 1'b0;
    repeat (HP - 18) @(negedge clk);
  endtask

  // Device model: waits for inhibit and release, samples data on every clock
  // rise (the release rise carries the start bit), and acks after the stop bit.
  task automatic dev_run(input int nfalls, input bit ack_low, input bit glitch_en);
    int t = 0;
    dev_bits = '1;
    dev_falls = 0;
    while (!ps2_clk_oe && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!ps2_clk_oe) begin
      check("dev_wait_inhibit", 32'(ps2_clk_oe), 32'd1);
      return;
    end
    t = 0;
    while (ps2_clk_oe && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (ps2_clk_oe) begin
      check("dev_wait_release", 32'(ps2_clk_oe), 32'd0);
      return;
    end
    repeat (4) @(negedge clk);
    dev_bits = {ps2_dat_in, dev_bits[10:1]};
    if (bus.tx_ready) ready_hi++;
    repeat (HP) @(negedge clk);
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      dev_falls = i;
      if (i == 1) fall1_cyc = cyc;
      half(glitch_en);
      dev_clk_low = 1'b0;
      if (i <= 10) begin
        dev_bits = {ps2_dat_in, dev_bits[10:1]};
        if (bus.tx_ready) ready_hi++;
      end
      if (i == 10 && ack_low) dev_dat_low = 1'b1;
      if (i == 11) dev_dat_low = 1'b0;
      half(glitch_en);
    end
    dev_dat_low = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int runs0;
    int acc2;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tx_done", 32'(bus.tx_done), 32'd0);
    check("rst_tx_err", 32'(bus.tx_err), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);

    // 0xF4: start 0, data 0,0,1,0,1,1,1,1, parity 0, stop 1.
    ready_hi = 0;
    push(1'b0, 2'b00, 1'b1, 11'h5E8);
    fork
      send_byte(8'hF4);
      dev_run(11, 1'b1, 1'b0);
    join
    check("f4_inhibit_len", 32'(inh_len), 32'(INH));
    wait_drain("f4_drain", 2000);
    check("f4_ready_low", 32'(ready_hi), 32'd0);

    // 0xED then 0xFF with tx_valid held; parity 1 for both.
    ready_hi = 0;
    done_log.delete();
    acc2 = 0;
    push(1'b0, 2'b00, 1'b1, 11'h7DA);
    push(1'b0, 2'b00, 1'b1, 11'h7FE);
    fork
      begin
        @(negedge clk);
        bus.tx_data = 8'hED;
        bus.tx_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        #1;
        bus.tx_data = 8'hFF;
        @(negedge clk);
        wait_ready();
        @(posedge clk);
        #1;
        acc2 = cyc;
        bus.tx_valid = 1'b0;
      end
      begin
        dev_run(11, 1'b1, 1'b0);
        check("ed_inhibit_len", 32'(inh_len), 32'(INH));
        dev_run(11, 1'b1, 1'b0);
        check("ff_inhibit_len", 32'(inh_len), 32'(INH));
      end
    join
    wait_drain("edff_drain", 2000);
    check("edff_ready_low", 32'(ready_hi), 32'd0);
    if (done_log.size() > 0) check("accept_after_done", 32'(acc2 > done_log[0]), 32'd1);
    else check("first_done_seen", 32'(done_log.size()), 32'd1);

    // Device never clocks: start timeout.
    runs0 = inh_runs;
    push(1'b1, 2'b01, 1'b0, 11'h000);
    send_byte(8'hA5);
    wait_drain("start_to_drain", (RETRIES + 1) * (INH + STO + 100) + 200);
    check("start_to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("start_to_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("start_to_inhibits", 32'(inh_runs - runs0), 32'(RETRIES + 1));

    // Data left high at fall 11: no acknowledge.
    push(1'b1, 2'b11, 1'b0, 11'h000);
    fork
      send_byte(8'h3C);
      repeat (RETRIES + 1) dev_run(11, 1'b0, 1'b0);
    join
    wait_drain("noack_drain", 3000);

    // Device stops after fall 5: frame timeout measured from fall 1.
    push(1'b1, 2'b10, 1'b0, 11'h000);
    fork
      send_byte(8'h81);
      repeat (RETRIES + 1) dev_run(5, 1'b1, 1'b0);
    join
    wait_drain("frame_to_drain", FTO + 500);
    check("frame_to_delay",
          32'((last_out_cyc - fall1_cyc) >= FTO && (last_out_cyc - fall1_cyc) <= FTO + 40), 32'd1);

    // Reset at fall 4 of a 0x00 frame releases the lines on the next edge.
    fork
      send_byte(8'h00);
      dev_run(11, 1'b1, 1'b0);
      begin
        int t = 0;
        while (dev_falls < 4 && t < 5000) begin
          @(negedge clk);
          t++;
        end
        repeat (20) @(negedge clk);
        check("pre_rst_dat_oe", 32'(ps2_dat_oe), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("mid_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (50) @(negedge clk);

    // 0x55 with 3-cycle glitches on ps2_clk in every half period.
    push(1'b0, 2'b00, 1'b1, 11'h6AA);
    fork
      send_byte(8'h55);
      dev_run(11, 1'b1, 1'b1);
    join
    wait_drain("glitch_drain", 2000);

    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
